lock_access_ctrl: RTL

//  Sequencing controller for the serial code lock. Frames serial key bits into

---
 rtl/lock_access_ctrl_if.sv | 39 +++
 rtl/lock_access_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lock_access_ctrl_if.sv
// rtl/lock_access_ctrl_if.sv - keypad/actuator signal bundle for the code lock controller.
// Optional LOCK_PROG_EN adds the code programming pair.
interface lock_access_ctrl_if #(
`ifdef LOCK_PROG_EN
    parameter int CODE_LEN = 4,
`endif
    parameter int MAX_FAIL = 3
);
    logic                            bit_valid;
    logic                            bit_in;
    logic                            abort;
    logic                            unlock;
    logic                            lockout;
    logic                            attempt_done;
    logic                            attempt_ok;
    logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt;
`ifdef LOCK_PROG_EN
    logic                            prog_valid;
    logic [CODE_LEN-1:0]             prog_code;

    modport master (
        output bit_valid, bit_in, abort, prog_valid, prog_code,
        input  unlock, lockout, attempt_done, attempt_ok, fail_cnt
    );
    modport slave (
        input  bit_valid, bit_in, abort, prog_valid, prog_code,
        output unlock, lockout, attempt_done, attempt_ok, fail_cnt
    );
`else
    modport master (
        output bit_valid, bit_in, abort,
        input  unlock, lockout, attempt_done, attempt_ok, fail_cnt
    );
    modport slave (
        input  bit_valid, bit_in, abort,
        output unlock, lockout, attempt_done, attempt_ok, fail_cnt
    );
`endif
endinterface

// File: rtl/lock_access_ctrl.sv
// rtl/lock_access_ctrl.sv - serial code lock sequencer: framing, compare, unlock window, lockout.
// Define LOCK_PROG_EN to make the code reprogrammable while the door is open.
module lock_access_ctrl #(
    parameter int              CODE_LEN    = 4,
    parameter logic [CODE_LEN-1:0] CODE    = 4'b1011,
    parameter int              MAX_FAIL    = 3,
    parameter int              UNLOCK_CYC  = 8,
    parameter int              LOCKOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    lock_access_ctrl_if.slave  bus
);
    localparam int FW    = $clog2(MAX_FAIL + 1);
    localparam int BW    = $clog2(CODE_LEN + 1);
    localparam int T_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_LEN-1:0] shift_q, shift_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [FW-1:0]       fail_cnt_q, fail_cnt_d;
    logic                unlock_q, unlock_d;
    logic                lockout_q, lockout_d;
    logic                done_q, done_d;
    logic                ok_q, ok_d;
    logic [CODE_LEN-1:0] code;
    logic                match;

`ifdef LOCK_PROG_EN
    logic [CODE_LEN-1:0] code_q;

    // Reprogramming is only trusted while the door is open after a valid code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= CODE;
        end else if (state_q == OPEN && bus.prog_valid) begin
            code_q <= bus.prog_code;
        end
    end
    assign code = code_q;
`else
    assign code = CODE;
`endif

    assign match = (shift_q == code);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            fail_cnt_q <= '0;
            unlock_q   <= 1'b0;
            lockout_q  <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            fail_cnt_q <= fail_cnt_d;
            unlock_q   <= unlock_d;
            lockout_q  <= lockout_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        fail_cnt_d = fail_cnt_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (bus.bit_valid) begin
                    shift_d   = (shift_q << 1) | CODE_LEN'(bus.bit_in);
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == BW'(CODE_LEN - 1)) ? CHECK : COLLECT;
                end
            end
            CHECK: begin
                done_d = 1'b1;
                ok_d   = match;
                if (match) begin
                    fail_cnt_d = '0;
                    state_d    = OPEN;
                    timer_d    = TW'(UNLOCK_CYC - 1);
                end else begin
                    fail_cnt_d = fail_cnt_q + 1'b1;
                    if (fail_cnt_q + 1'b1 == FW'(MAX_FAIL)) begin
                        state_d = LOCKOUT;
                        timer_d = TW'(LOCKOUT_CYC - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OPEN: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = IDLE;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any path back to IDLE starts the next attempt from an empty frame.
        if (state_d == IDLE) begin
            bit_cnt_d = '0;
        end

        unlock_d  = (state_d == OPEN);
        lockout_d = (state_d == LOCKOUT);
    end

    assign bus.unlock       = unlock_q;
    assign bus.lockout      = lockout_q;
    assign bus.attempt_done = done_q;
    assign bus.attempt_ok   = ok_q;
    assign bus.fail_cnt     = fail_cnt_q;

endmodule
